pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline (PC, IF_ID, Control_Unit/CU_mux, ID_EX, EX_MEM, MEM_WB). It produces the PC and IF_ID load enables, the IF_ID flush, the CU_mux bubble select (S), a whole-pipe hold for multi-cycle data memory, and the operand forwarding selects for the ID-stage A/B operand muxes. It tracks memory waits with an FSM and timeout, and keeps stall and flush event counters for debug.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive cycles spent waiting on mem_ready before an error is declared.
CNT_W, 16, width of the stall and flush counters.

Ports:
clk  in  1  pipeline clock; all state updates on posedge.
R  in  1  reset, synchronous, active-high.
ID_Rn  in  4  source register A of the instruction in ID (I[19:16]).
ID_Rm  in  4  source register B of the instruction in ID (I[3:0]).
ID_uses_Rn  in  1  ID instruction reads Rn.
ID_uses_Rm  in  1  ID instruction reads Rm.
EX_Rd  in  4  destination register in EX.
EX_RF_enable  in  1  EX instruction writes the register file.
EX_load_instr  in  1  EX instruction is a load.
MEM_Rd  in  4  destination register in MEM.
MEM_RF_enable  in  1  MEM instruction writes the register file.
MEM_Enable_signal  in  1  MEM instruction accesses data memory.
mem_ready  in  1  data memory access completes this cycle.
WB_Rd  in  4  destination register in WB.
WB_RF_enable  in  1  WB instruction writes the register file.
branch_taken  in  1  resolved taken B/BL in ID.
PC_LE  out  1  PC load enable.
IF_ID_LE  out  1  IF_ID load enable.
IF_ID_R  out  1  IF_ID flush, same cycle as PC redirect.
CU_S  out  1  CU_mux select: 1 inserts a NOP into ID_EX.
pipe_hold  out  1  freezes ID_EX, EX_MEM and MEM_WB.
fwd_a  out  2  A select: 00 RF, 01 EX, 10 MEM, 11 WB.
fwd_b  out  2  B select, same encoding, for Rm.
mem_error  out  1  sticky memory-timeout flag.
stall_count  out  CNT_W  cycles with PC_LE=0 (saturating).
flush_count  out  CNT_W  cycles with IF_ID_R=1 (saturating).

Behaviour:
- Reset (R=1 at posedge): state=RUN; wait_cnt, stall_count, flush_count=0; mem_error=0. While R=1, combinational outputs are forced to PC_LE=1, IF_ID_LE=1, IF_ID_R=0, CU_S=0, pipe_hold=0, fwd_a=fwd_b=00.
- Control outputs are combinational from current inputs and state, with zero-cycle latency. State and counters are registered.
- Forwarding for A, with priority top-down:
  - 01 if ID_uses_Rn, EX_RF_enable, !EX_load_instr and EX_Rd==ID_Rn.
  - else 10 if MEM_RF_enable and MEM_Rd==ID_Rn.
  - else 11 if WB_RF_enable and WB_Rd==ID_Rn.
  - else 00.
  - ID_Rn==15 always gives 00 (PC is never forwarded). B uses the same rules with Rm.
- load_use = EX_load_instr & EX_RF_enable & ((ID_uses_Rn & EX_Rd==ID_Rn & ID_Rn!=15) | (ID_uses_Rm & EX_Rd==ID_Rm & ID_Rm!=15)).
- mem_wait = MEM_Enable_signal & !mem_ready.
- FSM states: RUN, MEM_WAIT, MEM_ERR.
- RUN:
  - mem_wait: PC_LE=0, IF_ID_LE=0, pipe_hold=1, CU_S=0. Next state MEM_WAIT, wait_cnt=1.
  - else load_use: PC_LE=0, IF_ID_LE=0, CU_S=1 (one bubble). Stay in RUN. The bubble clears EX_RF_enable, so there is no re-detection next cycle.
  - else branch_taken: IF_ID_R=1, PC_LE=1.
  - else all enables 1, all other outputs 0.
- MEM_WAIT: hold outputs as above; load_use and branch_taken are ignored.
  - mem_ready=1: hold is released in the same cycle; next state RUN.
  - wait_cnt==MEM_TIMEOUT with mem_ready=0: mem_error<=1, release hold, next state MEM_ERR.
  - otherwise wait_cnt++.
- MEM_ERR: behaves as RUN, but mem_wait is ignored, so no further holds occur. Leaves only through R. mem_error stays 1 until R.
- Priority on simultaneous events: mem_wait > load_use > branch_taken. A stalled branch is re-presented by ID the next cycle.
- Counters: stall_count increments on each cycle with R=0 and PC_LE=0; flush_count increments on each cycle with IF_ID_R=1. Both saturate at all-ones and never wrap.
- Reset mid-MEM_WAIT: the next state is RUN and the hold drops in the reset cycle.

Test Plan:
1. ID_Rn=3, ID_uses_Rn=1; EX_Rd=3, EX_RF_enable=1, not load; MEM_Rd=3, MEM_RF_enable=1 -> fwd_a=01. Drop EX_RF_enable -> fwd_a=10. ID_Rn=15 -> fwd_a=00.
2. Load-use: EX_load_instr=1, EX_RF_enable=1, EX_Rd=5, ID_Rm=5, ID_uses_Rm=1 -> one cycle with PC_LE=0, IF_ID_LE=0, CU_S=1; stall_count=1. Next cycle (EX bubble, MEM_Rd=5) -> fwd_b=10, no stall.
3. MEM_Enable_signal=1, mem_ready=0 for 3 cycles, then 1 -> pipe_hold=1 for 3 cycles and released on the ready cycle; stall_count=3; state returns to RUN.
4. mem_ready held 0 with MEM_TIMEOUT=16 -> mem_error=1 after 16 waiting cycles, hold released, no further holds; R=1 clears mem_error.
5. branch_taken=1 together with load_use=1 -> stall only (IF_ID_R=0). Next cycle branch_taken=1 alone -> IF_ID_R=1, flush_count=1.
6. R asserted during MEM_WAIT -> that cycle pipe_hold=0, PC_LE=1; after reset state=RUN and both counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard sequencer.
// The master side drives the stage tags; the slave side returns enables, selects and debug state.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       ID_Rn;
    logic [3:0]       ID_Rm;
    logic             ID_uses_Rn;
    logic             ID_uses_Rm;
    logic [3:0]       EX_Rd;
    logic             EX_RF_enable;
    logic             EX_load_instr;
    logic [3:0]       MEM_Rd;
    logic             MEM_RF_enable;
    logic             MEM_Enable_signal;
    logic             mem_ready;
    logic [3:0]       WB_Rd;
    logic             WB_RF_enable;
    logic             branch_taken;
    logic             PC_LE;
    logic             IF_ID_LE;
    logic             IF_ID_R;
    logic             CU_S;
    logic             pipe_hold;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_Rn, ID_Rm, ID_uses_Rn, ID_uses_Rm,
        output EX_Rd, EX_RF_enable, EX_load_instr,
        output MEM_Rd, MEM_RF_enable, MEM_Enable_signal, mem_ready,
        output WB_Rd, WB_RF_enable, branch_taken,
        input  PC_LE, IF_ID_LE, IF_ID_R, CU_S, pipe_hold, fwd_a, fwd_b,
        input  mem_error, stall_count, flush_count
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_uses_Rn, ID_uses_Rm,
        input  EX_Rd, EX_RF_enable, EX_load_instr,
        input  MEM_Rd, MEM_RF_enable, MEM_Enable_signal, mem_ready,
        input  WB_Rd, WB_RF_enable, branch_taken,
        output PC_LE, IF_ID_LE, IF_ID_R, CU_S, pipe_hold, fwd_a, fwd_b,
        output mem_error, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: stall/flush/bubble enables, memory-wait hold
// with timeout, operand forwarding selects and saturating debug counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 R,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_MEM_ERR} state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic       pc_le, ifid_le, ifid_r, cu_s, hold;
    logic       load_use, mem_wait;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // R15 is the PC and is never forwarded; EX results from loads are not ready yet.
    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic uses);
        if (src == 4'd15)                                                  return 2'b00;
        if (uses && hz.EX_RF_enable && !hz.EX_load_instr && hz.EX_Rd == src) return 2'b01;
        if (hz.MEM_RF_enable && hz.MEM_Rd == src)                          return 2'b10;
        if (hz.WB_RF_enable && hz.WB_Rd == src)                            return 2'b11;
        return 2'b00;
    endfunction

    assign mem_wait = hz.MEM_Enable_signal & ~hz.mem_ready;
    assign load_use = hz.EX_load_instr & hz.EX_RF_enable &
                      ((hz.ID_uses_Rn & (hz.EX_Rd == hz.ID_Rn) & (hz.ID_Rn != 4'd15)) |
                       (hz.ID_uses_Rm & (hz.EX_Rd == hz.ID_Rm) & (hz.ID_Rm != 4'd15)));

    always_comb begin
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        ifid_r     = 1'b0;
        cu_s       = 1'b0;
        hold       = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == TMO) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_MEM_ERR;
                end else begin
                    pc_le      = 1'b0;
                    ifid_le    = 1'b0;
                    hold       = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                // ST_MEM_ERR shares RUN behaviour but never starts another memory hold.
                if (mem_wait && state_q == ST_RUN) begin
                    pc_le      = 1'b0;
                    ifid_le    = 1'b0;
                    hold       = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end else if (load_use) begin
                    pc_le   = 1'b0;
                    ifid_le = 1'b0;
                    cu_s    = 1'b1;
                end else if (hz.branch_taken) begin
                    ifid_r = 1'b1;
                end
            end
        endcase
        if (R) begin
            pc_le      = 1'b1;
            ifid_le    = 1'b1;
            ifid_r     = 1'b0;
            cu_s       = 1'b0;
            hold       = 1'b0;
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            mem_err_d  = 1'b0;
        end
    end

    assign fwd_a = R ? 2'b00 : fwd_sel(hz.ID_Rn, hz.ID_uses_Rn);
    assign fwd_b = R ? 2'b00 : fwd_sel(hz.ID_Rm, hz.ID_uses_Rm);

    always_ff @(posedge clk) begin
        if (R) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_le) stall_q <= sat_inc(stall_q);
            if (ifid_r) flush_q <= sat_inc(flush_q);
        end
        state_q    <= state_d;
        wait_cnt_q <= wait_cnt_d;
        mem_err_q  <= mem_err_d;
    end

    assign hz.PC_LE       = pc_le;
    assign hz.IF_ID_LE    = ifid_le;
    assign hz.IF_ID_R     = ifid_r;
    assign hz.CU_S        = cu_s;
    assign hz.pipe_hold   = hold;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.mem_error   = mem_err_q;
    assign hz.stall_count = stall_q;
    assign hz.flush_count = flush_q;
endmodule
